// File: rtl/window_scan_ctrl_if.sv
// Bundle of the scan controller's non-clock signals.
//
// Valid/ready rule for the edge channel: an edge result moves on a rising
// clock edge where edge_valid and edge_ready are both high. While edge_valid
// is high and edge_ready is low, edge_bit, edge_row and edge_col hold steady
// and edge_valid stays high. The memory read is fixed-latency: rd_data
// carries the word for a rd_en/rd_addr issued one cycle earlier.
//
// Signals:
//   start, busy, done           - scan control
//   rd_en, rd_addr, rd_data     - single-port pixel memory read
//   buffer_input[0:2]           - three pixel slots to the window buffer
//   shift_enable, shift_direction
//   hysteresis_enable, hysteresis_out
//   edge_valid, edge_ready, edge_bit, edge_row, edge_col
interface window_scan_ctrl_if #(
    parameter int ADDR_W  = 6,
    parameter int COORD_W = 8
);
    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [7:0]         rd_data;
    logic [7:0]         buffer_input [0:2];
    logic               shift_enable;
    logic [1:0]         shift_direction;
    logic               hysteresis_enable;
    logic               hysteresis_out;
    logic               edge_valid;
    logic               edge_ready;
    logic               edge_bit;
    logic [COORD_W-1:0] edge_row;
    logic [COORD_W-1:0] edge_col;

    modport master (
        input  start,
        output busy, done,
        output rd_en, rd_addr,
        input  rd_data,
        output buffer_input, shift_enable, shift_direction, hysteresis_enable,
        input  hysteresis_out,
        output edge_valid,
        input  edge_ready,
        output edge_bit, edge_row, edge_col
    );

    modport slave (
        output start,
        input  busy, done,
        input  rd_en, rd_addr,
        output rd_data,
        input  buffer_input, shift_enable, shift_direction, hysteresis_enable,
        output hysteresis_out,
        input  edge_valid,
        output edge_ready,
        input  edge_bit, edge_row, edge_col
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// Serpentine scan controller feeding a 3x3 window buffer with hysteresis.
// Each step fetches three pixels (a new column for right/left moves, a new
// row for down moves), shifts them into the window, and once the window is
// primed evaluates hysteresis and emits one edge bit with the window centre.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - window_scan_ctrl_if.master (control, memory, buffer, edge)
//   state_dbg  - current FSM state encoding (IDLE=0 .. DONE=5)
module window_scan_ctrl #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 6,
    parameter int ADDR_W  = 6,
    parameter int COORD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    window_scan_ctrl_if.master  bus,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        EVAL  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    state_e             state_q, state_d;
    logic [1:0]         fetch_k_q;      // FETCH sub-cycle 0..3
    logic [1:0]         prime_cnt_q;    // right shifts done while priming, 3 = primed
    logic [1:0]         step_dir_q;     // direction of the step being fetched
    logic               horiz_right_q;  // horizontal direction of the current band row
    logic [COORD_W-1:0] row_q, col_q;   // window centre
    logic [7:0]         buf_q [0:2];
    logic               edge_bit_q;
    logic [COORD_W-1:0] edge_row_q, edge_col_q;

    logic               priming;
    logic               at_row_end;
    logic               last_row;
    logic [COORD_W-1:0] slot_row, slot_col;
    logic [ADDR_W-1:0]  slot_addr;

    logic               rd_en_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic               shift_en_c;
    logic [1:0]         shift_dir_c;
    logic               hyst_en_c;
    logic               edge_valid_c;

    assign priming  = (prime_cnt_q != 2'd3);
    assign last_row = (row_q >= COORD_W'(IMG_H - 2));
    // The end-of-row bound depends on which way the band is running.
    assign at_row_end = horiz_right_q ? (col_q >= COORD_W'(IMG_W - 2))
                                      : (col_q <= COORD_W'(1));

    // Pixel coordinate of slot fetch_k_q for the pending step. During
    // priming the centre column sits at 0 and columns 0,1,2 are fetched.
    always_comb begin
        slot_row = '0;
        slot_col = '0;
        if (step_dir_q == DIR_DOWN) begin
            slot_row = row_q + COORD_W'(2);
            slot_col = col_q - COORD_W'(1) + COORD_W'(fetch_k_q);
        end else begin
            slot_row = row_q - COORD_W'(1) + COORD_W'(fetch_k_q);
            if (priming)
                slot_col = COORD_W'(prime_cnt_q);
            else if (step_dir_q == DIR_RIGHT)
                slot_col = col_q + COORD_W'(2);
            else
                slot_col = col_q - COORD_W'(2);
        end
    end

    assign slot_addr = ADDR_W'(int'(slot_row) * IMG_W + int'(slot_col));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rd_en_c      = 1'b0;
        rd_addr_c    = '0;
        shift_en_c   = 1'b0;
        shift_dir_c  = 2'b00;
        hyst_en_c    = 1'b0;
        edge_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                // Three reads, then one extra cycle to capture the last word.
                if (fetch_k_q != 2'd3) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = slot_addr;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en_c  = 1'b1;
                shift_dir_c = step_dir_q;
                state_d     = (priming && prime_cnt_q != 2'd2) ? FETCH : EVAL;
            end
            EVAL: begin
                hyst_en_c = 1'b1;
                state_d   = EMIT;
            end
            EMIT: begin
                edge_valid_c = 1'b1;
                if (bus.edge_ready)
                    state_d = (at_row_end && last_row) ? DONE : FETCH;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_k_q     <= '0;
            prime_cnt_q   <= '0;
            step_dir_q    <= DIR_RIGHT;
            horiz_right_q <= 1'b1;
            row_q         <= '0;
            col_q         <= '0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
            edge_bit_q    <= 1'b0;
            edge_row_q    <= '0;
            edge_col_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        row_q         <= COORD_W'(1);
                        col_q         <= '0;
                        prime_cnt_q   <= '0;
                        fetch_k_q     <= '0;
                        step_dir_q    <= DIR_RIGHT;
                        horiz_right_q <= 1'b1;
                    end
                end
                FETCH: begin
                    // Wraps back to 0 on the capture-only cycle.
                    fetch_k_q <= fetch_k_q + 2'd1;
                    case (fetch_k_q)
                        2'd1:    buf_q[0] <= bus.rd_data;
                        2'd2:    buf_q[1] <= bus.rd_data;
                        2'd3:    buf_q[2] <= bus.rd_data;
                        default: ;
                    endcase
                end
                SHIFT: begin
                    if (priming) begin
                        prime_cnt_q <= prime_cnt_q + 2'd1;
                        // Third priming column lands the centre on column 1.
                        if (prime_cnt_q == 2'd2) col_q <= col_q + COORD_W'(1);
                    end else begin
                        case (step_dir_q)
                            DIR_RIGHT: col_q <= col_q + COORD_W'(1);
                            DIR_LEFT:  col_q <= col_q - COORD_W'(1);
                            DIR_DOWN:  row_q <= row_q + COORD_W'(1);
                            default:   ;
                        endcase
                    end
                end
                EVAL: begin
                    edge_bit_q <= bus.hysteresis_out;
                    edge_row_q <= row_q;
                    edge_col_q <= col_q;
                end
                EMIT: begin
                    if (bus.edge_ready && !(at_row_end && last_row)) begin
                        if (at_row_end) begin
                            step_dir_q    <= DIR_DOWN;
                            horiz_right_q <= ~horiz_right_q;
                        end else begin
                            step_dir_q <= horiz_right_q ? DIR_RIGHT : DIR_LEFT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = (state_q == DONE);
    assign bus.rd_en             = rd_en_c;
    assign bus.rd_addr           = rd_addr_c;
    assign bus.buffer_input[0]   = buf_q[0];
    assign bus.buffer_input[1]   = buf_q[1];
    assign bus.buffer_input[2]   = buf_q[2];
    assign bus.shift_enable      = shift_en_c;
    assign bus.shift_direction   = shift_dir_c;
    assign bus.hysteresis_enable = hyst_en_c;
    assign bus.edge_valid        = edge_valid_c;
    assign bus.edge_bit          = edge_bit_q;
    assign bus.edge_row          = edge_row_q;
    assign bus.edge_col          = edge_col_q;
    assign state_dbg             = state_q;
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl on an 8x6 image. Expected edges, read addresses
// and shift payloads are derived from the serpentine centre list and pushed
// into queues before each scan; negedge monitors pop and compare them.
module tb_window_scan_ctrl;
    localparam int IMG_W   = 8;
    localparam int IMG_H   = 6;
    localparam int ADDR_W  = 6;
    localparam int COORD_W = 8;
    localparam int NE      = (IMG_W - 2) * (IMG_H - 2);
    localparam int EW      = 1 + 2 * COORD_W;
    localparam int SW      = 2 + 24;

    logic       tb_clk = 1'b0;
    logic       rst    = 1'b1;
    logic [2:0] state_dbg;

    window_scan_ctrl_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus();

    window_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 tb_clk = ~tb_clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [SW-1:0]     sh_q[$];
    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int eval_cnt = 0;
    int stall_idx = -1;
    int stall_len = 0;
    int stall_cnt = 0;
    logic       pend_v = 1'b0;
    logic [7:0] pend_a = 8'h00;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
    endtask

    function automatic int pix(input int r, input int c);
        return r * IMG_W + c;
    endfunction

    task automatic push_step(input logic [1:0] dir, input int a0, input int a1, input int a2);
        addr_q.push_back(ADDR_W'(a0));
        addr_q.push_back(ADDR_W'(a1));
        addr_q.push_back(ADDR_W'(a2));
        sh_q.push_back({dir, 8'(a0), 8'(a1), 8'(a2)});
    endtask

    // Full-scan expectations from the serpentine centre list.
    task automatic push_scan();
        int er[NE];
        int ec[NE];
        int n = 0;
        for (int r = 1; r <= IMG_H - 2; r++)
            for (int j = 0; j < IMG_W - 2; j++) begin
                er[n] = r;
                ec[n] = (r % 2 == 1) ? 1 + j : IMG_W - 2 - j;
                n++;
            end
        for (int j = 0; j < 3; j++) push_step(2'b01, pix(0, j), pix(1, j), pix(2, j));
        for (int e = 0; e < NE; e++) begin
            if (e > 0) begin
                if (er[e] != er[e-1])
                    push_step(2'b11, pix(er[e-1] + 2, ec[e-1] - 1),
                              pix(er[e-1] + 2, ec[e-1]), pix(er[e-1] + 2, ec[e-1] + 1));
                else if (ec[e] > ec[e-1])
                    push_step(2'b01, pix(er[e] - 1, ec[e] + 1),
                              pix(er[e], ec[e] + 1), pix(er[e] + 1, ec[e] + 1));
                else
                    push_step(2'b10, pix(er[e] - 1, ec[e] - 1),
                              pix(er[e], ec[e] - 1), pix(er[e] + 1, ec[e] - 1));
            end
            exp_q.push_back({(er[e] == 2 && ec[e] == 3) ? 1'b1 : 1'b0,
                             COORD_W'(er[e]), COORD_W'(ec[e])});
        end
    endtask

    task automatic check_zero(input string name);
        logic [54:0] v;
        v = {bus.busy, bus.done, bus.rd_en, bus.rd_addr,
             bus.buffer_input[0], bus.buffer_input[1], bus.buffer_input[2],
             bus.shift_enable, bus.shift_direction, bus.hysteresis_enable,
             bus.edge_valid, bus.edge_bit, bus.edge_row, bus.edge_col};
        chk(name, 64'(v), 64'd0);
        chk({name, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- memory and hysteresis models ----------------
    // Memory returns the address as data, one cycle after the read.
    always @(negedge tb_clk) begin
        bus.rd_data = pend_v ? pend_a : 8'h00;
        pend_v = bus.rd_en;
        pend_a = 8'(bus.rd_addr);
        // The tenth evaluation of a scan is centre (2,3).
        bus.hysteresis_out = bus.hysteresis_enable && (eval_cnt == 9);
        if (bus.hysteresis_enable) eval_cnt++;
    end

    // ---------------- monitors ----------------
    always @(negedge tb_clk) begin
        if (bus.rd_en) begin
            if (addr_q.size() == 0) fail_now("rd_addr");
            else chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
        end
        if (bus.shift_enable) begin
            if (sh_q.size() == 0) fail_now("shift");
            else chk("shift_dir_buf",
                     64'({bus.shift_direction, bus.buffer_input[0],
                          bus.buffer_input[1], bus.buffer_input[2]}),
                     64'(sh_q.pop_front()));
        end
        if (bus.done) done_cnt++;
    end

    always @(negedge tb_clk) begin
        if (rst) begin
            bus.edge_ready = 1'b1;
            stall_cnt = 0;
        end else if (bus.edge_valid) begin
            if (hs_cnt == stall_idx && stall_cnt < stall_len) begin
                bus.edge_ready = 1'b0;
                stall_cnt++;
                if (exp_q.size() == 0) fail_now("stall_hold");
                else chk("stall_hold", 64'({bus.edge_bit, bus.edge_row, bus.edge_col}),
                         64'(exp_q[0]));
                chk("stall_quiet", 64'({bus.rd_en, bus.shift_enable, bus.hysteresis_enable}),
                    64'd0);
            end else begin
                bus.edge_ready = 1'b1;
                if (exp_q.size() == 0) fail_now("edge");
                else chk("edge", 64'({bus.edge_bit, bus.edge_row, bus.edge_col}),
                         64'(exp_q.pop_front()));
                hs_cnt++;
                stall_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge tb_clk);
        bus.start = 1'b1;
        @(negedge tb_clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done_and_check(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge tb_clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_handshakes"}, 64'(hs_cnt), 64'(NE));
        @(negedge tb_clk);
        chk({tag, "_busy_fall"}, 64'({bus.busy, bus.done}), 64'd0);
        repeat (3) @(negedge tb_clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_edges_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_reads_left"}, 64'(addr_q.size()), 64'd0);
        chk({tag, "_shifts_left"}, 64'(sh_q.size()), 64'd0);
    endtask

    task automatic clear_run();
        exp_q.delete();
        addr_q.delete();
        sh_q.delete();
        hs_cnt = 0;
        done_cnt = 0;
        eval_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        bus.start = 1'b0;
        bus.edge_ready = 1'b1;
        bus.rd_data = 8'h00;
        bus.hysteresis_out = 1'b0;
        rst = 1'b1;

        // Reset held two cycles with start asserted during it.
        @(negedge tb_clk);
        bus.start = 1'b1;
        @(negedge tb_clk);
        check_zero("reset");
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge tb_clk);
        chk("start_in_reset_ignored", 64'({bus.busy, bus.rd_en}), 64'd0);

        // Full scan with back-pressure on the third edge, centre (1,3).
        clear_run();
        push_scan();
        stall_idx = 2;
        stall_len = 5;
        pulse_start();
        wait_done_and_check("scan1");

        // Mid-scan reset while the tenth edge, centre (2,3), is held.
        clear_run();
        push_scan();
        stall_idx = 9;
        stall_len = 100000;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge tb_clk);
            #1;
            if (bus.edge_valid && hs_cnt == 9) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_edge10", 64'(found), 64'd1);
        @(negedge tb_clk);
        rst = 1'b1;
        @(negedge tb_clk);
        check_zero("midscan_reset");
        rst = 1'b0;
        stall_idx = -1;
        stall_len = 0;
        repeat (6) @(negedge tb_clk);
        chk("midscan_no_done", 64'(done_cnt), 64'd0);
        chk("midscan_idle", 64'({bus.busy, bus.rd_en, bus.edge_valid}), 64'd0);

        // Fresh scan after the abort.
        clear_run();
        push_scan();
        pulse_start();
        wait_done_and_check("scan2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
